// File: rtl/ascon_decrypt_if.sv
// Block-level bundle for ascon_decrypt: message setup, 64-bit data handshake and results.
// Optional computed-tag output tag_o is present when ASCON_TAG_OUT_EN is defined.
interface ascon_decrypt_if;
   logic         start_i;
   logic [127:0] key_i;
   logic [127:0] nonce_i;
   logic [127:0] tag_i;
   logic [63:0]  data_i;
   logic         data_valid_i;
   logic         ready_o;
   logic [63:0]  plain_o;
   logic         plain_valid_o;
   logic         tag_ok_o;
   logic         end_o;
`ifdef ASCON_TAG_OUT_EN
   logic [127:0] tag_o;
`endif

   modport master (
      output start_i, key_i, nonce_i, tag_i, data_i, data_valid_i,
      input  ready_o, plain_o, plain_valid_o, tag_ok_o, end_o
`ifdef ASCON_TAG_OUT_EN
      , input tag_o
`endif
   );

   modport slave (
      input  start_i, key_i, nonce_i, tag_i, data_i, data_valid_i,
      output ready_o, plain_o, plain_valid_o, tag_ok_o, end_o
`ifdef ASCON_TAG_OUT_EN
      , output tag_o
`endif
   );
endinterface

// File: rtl/ascon_decrypt.sv
// ASCON-128 authenticated decryption, one permutation round per cycle, 64-bit block interface.
// Define ASCON_TAG_OUT_EN to expose the recomputed tag on bus.tag_o.
module ascon_decrypt #(
   parameter int AD_BLOCKS = 1,
   parameter int CT_BLOCKS = 3
) (
   input logic            clock_i,
   input logic            reset_i,
   ascon_decrypt_if.slave bus
);
   localparam logic [63:0] IV  = 64'h80400c0600000000;
   localparam int          ADW = (AD_BLOCKS > 1) ? $clog2(AD_BLOCKS) : 1;
   localparam int          CTW = (CT_BLOCKS > 1) ? $clog2(CT_BLOCKS) : 1;

   typedef enum logic [2:0] {IDLE, INIT, AD_WAIT, AD_PERM, CT_WAIT, CT_PERM, FINAL, DONE} state_t;
   // word [0] is x0 ... word [4] is x4
   typedef logic [4:0][63:0] ascon_st_t;

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic ascon_st_t ascon_round(input ascon_st_t s, input logic [3:0] r);
      ascon_st_t x;
      ascon_st_t t;
      x    = s;
      x[2] = x[2] ^ {56'd0, ~r, r};
      x[0] = x[0] ^ x[4];
      x[4] = x[4] ^ x[3];
      x[2] = x[2] ^ x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i + 1) % 5];
      x[1] = x[1] ^ x[0];
      x[0] = x[0] ^ x[4];
      x[3] = x[3] ^ x[2];
      x[2] = ~x[2];
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
      return x;
   endfunction

   state_t           state_q, state_n;
   ascon_st_t        s_q, s_n, rnd_s;
   logic [127:0]     key_q, key_n, tag_q, tag_n, tag_calc;
   logic [3:0]       rnd_q, rnd_n;
   logic [ADW-1:0]   ad_q, ad_n;
   logic [CTW-1:0]   ct_q, ct_n;
   logic [63:0]      plain_q, plain_n;
   logic             pv_q, pv_n, ok_q, ok_n, end_q, end_n;

   assign rnd_s    = ascon_round(s_q, rnd_q);
   assign tag_calc = {rnd_s[3], rnd_s[4]} ^ key_q;

   always_comb begin
      state_n = state_q;
      s_n     = s_q;
      key_n   = key_q;
      tag_n   = tag_q;
      rnd_n   = rnd_q;
      ad_n    = ad_q;
      ct_n    = ct_q;
      plain_n = plain_q;
      pv_n    = 1'b0;
      ok_n    = ok_q;
      end_n   = end_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start_i) begin
               s_n     = {bus.nonce_i[63:0], bus.nonce_i[127:64],
                          bus.key_i[63:0], bus.key_i[127:64], IV};
               key_n   = bus.key_i;
               tag_n   = bus.tag_i;
               rnd_n   = 4'd0;
               ad_n    = '0;
               ct_n    = '0;
               ok_n    = 1'b0;
               end_n   = 1'b0;
               state_n = INIT;
            end
         end
         INIT: begin
            s_n   = rnd_s;
            rnd_n = rnd_q + 4'd1;
            if (rnd_q == 4'd11) begin
               s_n[3]  = rnd_s[3] ^ key_q[127:64];
               s_n[4]  = rnd_s[4] ^ key_q[63:0];
               state_n = AD_WAIT;
            end
         end
         AD_WAIT: begin
            if (bus.data_valid_i) begin
               s_n[0]  = s_q[0] ^ bus.data_i;
               rnd_n   = 4'd6;
               state_n = AD_PERM;
            end
         end
         AD_PERM: begin
            s_n   = rnd_s;
            rnd_n = rnd_q + 4'd1;
            if (rnd_q == 4'd11) begin
               if (ad_q == ADW'(AD_BLOCKS - 1)) begin
                  // domain separation between AD and ciphertext
                  s_n[4]  = rnd_s[4] ^ 64'd1;
                  ad_n    = '0;
                  state_n = CT_WAIT;
               end else begin
                  ad_n    = ad_q + ADW'(1);
                  state_n = AD_WAIT;
               end
            end
         end
         CT_WAIT: begin
            if (bus.data_valid_i) begin
               plain_n = s_q[0] ^ bus.data_i;
               pv_n    = 1'b1;
               s_n[0]  = bus.data_i;
               if (ct_q == CTW'(CT_BLOCKS - 1)) begin
                  s_n[1]  = s_q[1] ^ key_q[127:64];
                  s_n[2]  = s_q[2] ^ key_q[63:0];
                  ct_n    = '0;
                  rnd_n   = 4'd0;
                  state_n = FINAL;
               end else begin
                  ct_n    = ct_q + CTW'(1);
                  rnd_n   = 4'd6;
                  state_n = CT_PERM;
               end
            end
         end
         CT_PERM: begin
            s_n   = rnd_s;
            rnd_n = rnd_q + 4'd1;
            if (rnd_q == 4'd11) state_n = CT_WAIT;
         end
         FINAL: begin
            s_n   = rnd_s;
            rnd_n = rnd_q + 4'd1;
            if (rnd_q == 4'd11) begin
               ok_n    = (tag_calc == tag_q);
               end_n   = 1'b1;
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         s_q     <= '0;
         key_q   <= '0;
         tag_q   <= '0;
         rnd_q   <= '0;
         ad_q    <= '0;
         ct_q    <= '0;
         plain_q <= '0;
         pv_q    <= 1'b0;
         ok_q    <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         s_q     <= s_n;
         key_q   <= key_n;
         tag_q   <= tag_n;
         rnd_q   <= rnd_n;
         ad_q    <= ad_n;
         ct_q    <= ct_n;
         plain_q <= plain_n;
         pv_q    <= pv_n;
         ok_q    <= ok_n;
         end_q   <= end_n;
      end
   end

`ifdef ASCON_TAG_OUT_EN
   logic [127:0] tag_out_q;
   always_ff @(posedge clock_i) begin
      if (reset_i)                                tag_out_q <= '0;
      else if (state_q == FINAL && rnd_q == 4'd11) tag_out_q <= tag_calc;
   end
   assign bus.tag_o = tag_out_q;
`endif

   assign bus.ready_o       = (state_q == AD_WAIT) || (state_q == CT_WAIT);
   assign bus.plain_o       = plain_q;
   assign bus.plain_valid_o = pv_q;
   assign bus.tag_ok_o      = ok_q;
   assign bus.end_o         = end_q;
endmodule

// File: tb/tb_ascon_decrypt.sv
// Randomized bench for ascon_decrypt: messages are built by an ASCON-128 encryption model
// (table S-box) and the DUT must recover the plaintext, latencies and tag verdict.
module tb_ascon_decrypt;
   localparam int AD_B = 1;
   localparam int CT_B = 3;
   localparam logic [63:0] IV = {8'd128, 8'd64, 8'd12, 8'd6, 32'd0};
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ascon_decrypt_if bus();
   ascon_decrypt #(.AD_BLOCKS(AD_B), .CT_BLOCKS(CT_B)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q [$];
   logic [63:0] mx [5];
   logic [63:0] m_ad [AD_B];
   logic [63:0] m_pt [CT_B];
   logic [63:0] m_ct [CT_B];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [7:0] rc(input int r);
      return 8'(8'hf0 - 8'(r) * 8'h0f);
   endfunction

   task automatic m_perm(input int nr);
      logic [4:0]  v;
      logic [63:0] y [5];
      for (int r = 12 - nr; r < 12; r++) begin
         mx[2] = mx[2] ^ {56'd0, rc(r)};
         for (int j = 0; j < 64; j++) begin
            v = SBOX[{mx[0][j], mx[1][j], mx[2][j], mx[3][j], mx[4][j]}];
            y[0][j] = v[4]; y[1][j] = v[3]; y[2][j] = v[2]; y[3][j] = v[1]; y[4][j] = v[0];
         end
         mx[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
         mx[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
         mx[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
         mx[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
         mx[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
      end
   endtask

   task automatic m_init(input logic [127:0] k, input logic [127:0] n);
      mx[0] = IV; mx[1] = k[127:64]; mx[2] = k[63:0]; mx[3] = n[127:64]; mx[4] = n[63:0];
      m_perm(12);
      mx[3] ^= k[127:64];
      mx[4] ^= k[63:0];
   endtask

   task automatic m_encrypt(input logic [127:0] k, input logic [127:0] n, output logic [127:0] t);
      m_init(k, n);
      for (int a = 0; a < AD_B; a++) begin
         mx[0] ^= m_ad[a];
         m_perm(6);
      end
      mx[4] ^= 64'd1;
      for (int c = 0; c < CT_B; c++) begin
         m_ct[c] = mx[0] ^ m_pt[c];
         mx[0]   = m_ct[c];
         if (c < CT_B - 1) m_perm(6);
      end
      mx[1] ^= k[127:64];
      mx[2] ^= k[63:0];
      m_perm(12);
      t = {mx[3] ^ k[127:64], mx[4] ^ k[63:0]};
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (bus.plain_valid_o) begin
         if (exp_q.size() == 0) chk("plain_unexpected", 128'(bus.plain_o), 128'(1'b0) - 128'd1);
         else chk("plain", 128'(bus.plain_o), 128'(exp_q.pop_front()));
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_ready"},  128'(bus.ready_o), 128'd0);
      chk({pfx, "_plain"},  128'(bus.plain_o), 128'd0);
      chk({pfx, "_pvalid"}, 128'(bus.plain_valid_o), 128'd0);
      chk({pfx, "_tagok"},  128'(bus.tag_ok_o), 128'd0);
      chk({pfx, "_end"},    128'(bus.end_o), 128'd0);
   endtask

   task automatic wait_for(input bit want_end, input bit noise, output int n);
      n = 0;
      do begin
         step();
         n++;
         if (!(want_end ? bus.end_o : bus.ready_o)) begin
            bus.data_valid_i = noise && ($urandom_range(0, 1) == 1);
            bus.data_i       = {$urandom, $urandom};
         end
      end while (!(want_end ? bus.end_o : bus.ready_o) && n < 40);
      bus.data_valid_i = 1'b0;
   endtask

   task automatic send(input logic [63:0] d, input bit noise);
      repeat ($urandom_range(0, 2)) step();
      if (noise) begin
         // stray start and changed setup inputs while busy must be ignored
         bus.start_i = 1'b1;
         bus.key_i   = {$urandom, $urandom, $urandom, $urandom};
         bus.tag_i   = {$urandom, $urandom, $urandom, $urandom};
         step();
         bus.start_i = 1'b0;
      end
      bus.data_i       = d;
      bus.data_valid_i = 1'b1;
      step();
      bus.data_valid_i = 1'b0;
   endtask

   task automatic run_msg(input logic [127:0] k, input logic [127:0] n, input logic [127:0] flip,
                          input bit noise, input int abort_at);
      logic [127:0] t;
      int           lat;
      m_encrypt(k, n, t);
      bus.key_i        = k;
      bus.nonce_i      = n;
      bus.tag_i        = t ^ flip;
      bus.start_i      = 1'b1;
      bus.data_valid_i = noise;
      bus.data_i       = {$urandom, $urandom};
      step();
      bus.start_i      = 1'b0;
      bus.data_valid_i = 1'b0;
      chk("end_clear", 128'(bus.end_o), 128'd0);
      chk("tagok_clear", 128'(bus.tag_ok_o), 128'd0);
      wait_for(1'b0, noise, lat);
      chk("init_latency", 128'(lat), 128'd12);
      for (int a = 0; a < AD_B; a++) begin
         send(m_ad[a], 1'b0);
         wait_for(1'b0, noise, lat);
         chk("ad_latency", 128'(lat), 128'd6);
      end
      for (int c = 0; c < CT_B; c++) begin
         exp_q.push_back(m_pt[c]);
         send(m_ct[c], noise);
         if (c == CT_B - 1) begin
            wait_for(1'b1, noise, lat);
            chk("end_latency", 128'(lat), 128'd12);
         end else begin
            wait_for(1'b0, noise, lat);
            chk("ct_latency", 128'(lat), 128'd6);
            if (c == abort_at) begin
               rst = 1'b1;
               repeat (3) step();
               chk_zero("abort");
               rst = 1'b0;
               step();
               chk("abort_pending_plain", 128'(exp_q.size()), 128'd0);
               return;
            end
         end
      end
      chk("tag_ok", 128'(bus.tag_ok_o), 128'(flip == '0));
      chk("plain_count", 128'(exp_q.size()), 128'd0);
`ifdef ASCON_TAG_OUT_EN
      chk("tag_out", bus.tag_o, t);
`endif
      repeat (2) begin
         bus.data_valid_i = noise;
         step();
      end
      bus.data_valid_i = 1'b0;
      chk("end_hold", 128'(bus.end_o), 128'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] k, n, flip, kk;
      bus.start_i = 1'b0; bus.key_i = '0; bus.nonce_i = '0; bus.tag_i = '0;
      bus.data_i = '0; bus.data_valid_i = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      chk_zero("reset");
      rst = 1'b0;
      step();

      // pin the model against hand values and a published empty-message vector
      chk("pin_rc0",  128'(rc(0)),  128'h0f0);
      chk("pin_rc1",  128'(rc(1)),  128'h0e1);
      chk("pin_rc11", 128'(rc(11)), 128'h04b);
      kk = 128'h000102030405060708090a0b0c0d0e0f;
      m_init(kk, kk);
      mx[4] ^= 64'd1;
      mx[0] ^= 64'h8000000000000000;
      mx[1] ^= kk[127:64];
      mx[2] ^= kk[63:0];
      m_perm(12);
      chk("pin_kat_tag", {mx[3] ^ kk[127:64], mx[4] ^ kk[63:0]}, 128'he355159f292911f794cb1432a0103a8a);

      k = 128'h000102030405060708090a0b0c0d0e0f;
      n = 128'h00112233445566778899aabbccddeeff;
      m_ad[0] = 64'h3230323380000000;
      m_pt[0] = 64'h0001020304050607;
      m_pt[1] = 64'h08090a0b0c0d0e0f;
      m_pt[2] = 64'h1011121314151617;
      run_msg(k, n, '0, 1'b0, -1);          // nominal message
      run_msg(k, n, 128'd1, 1'b0, -1);      // tag bit 0 flipped
      run_msg(k, n, '0, 1'b1, -1);          // stray valid/start pulses
      run_msg(k, n, '0, 1'b0, 1);           // reset mid CT_WAIT
      run_msg(k, n, '0, 1'b0, -1);          // clean message after reset
      run_msg(k, n, '0, 1'b0, -1);          // back-to-back from DONE

      for (int m = 0; m < 16; m++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         n = {$urandom, $urandom, $urandom, $urandom};
         for (int a = 0; a < AD_B; a++) m_ad[a] = {$urandom, $urandom};
         for (int c = 0; c < CT_B; c++) m_pt[c] = {$urandom, $urandom};
         flip = '0;
         if ($urandom_range(0, 3) == 0) flip[$urandom_range(0, 127)] = 1'b1;
         run_msg(k, n, flip, ($urandom_range(0, 1) == 1), -1);
      end

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
